// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - DVI control tokens and lane-decoder state encoding
package dvi_pkg;

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational 10b TMDS symbol to token/control/byte decoder
module tmds_symbol_decode
    import dvi_pkg::*;
(
    input  logic [9:0] q,
    output logic       is_token,
    output logic [1:0] c,
    output logic [7:0] data
);

    logic [7:0] d;

    assign d = q[9] ? ~q[7:0] : q[7:0];

    always_comb begin
        is_token = 1'b1;
        c        = 2'b00;
        case (q)
            CTL_00:  c = 2'b00;
            CTL_01:  c = 2'b01;
            CTL_10:  c = 2'b10;
            CTL_11:  c = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    // q[8] selects whether the transmitter chained bits with XOR or XNOR
    always_comb begin
        data    = 8'd0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS lane word alignment, lock tracking and decode
module tmds_channel_decoder
    import dvi_pkg::*;
#(
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOCK_TOKENS   = 32
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       de,
    output logic       valid,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int TW = $clog2(SEARCH_WINDOW);
    localparam int CW = $clog2(LOCK_TOKENS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SEARCH_WINDOW - 1);
    localparam logic [CW-1:0] L_TOK  = CW'(LOCK_TOKENS);

    logic [9:0]    prev_raw_q, prev_raw_d;
    logic [9:0]    aligned_q, aligned_d;
    logic [3:0]    aligned_off_q, aligned_off_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    offset_q, offset_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] tok_cnt_q, tok_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    c_q, c_d;
    logic          de_q, de_d;
    logic          valid_q, valid_d;

    logic [19:0] cat;
    logic [3:0]  offset_adv;
    logic        holdoff, tok_seen, expire;
    logic        sym_is_token;
    logic [1:0]  sym_c;
    logic [7:0]  sym_data;

    tmds_symbol_decode u_sym (
        .q        (aligned_q),
        .is_token (sym_is_token),
        .c        (sym_c),
        .data     (sym_data)
    );

    assign cat        = {raw_word, prev_raw_q};
    assign offset_adv = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    // stage-2 word still carries the previous offset right after a change
    assign holdoff    = (aligned_off_q != offset_q);
    assign tok_seen   = sym_is_token && !holdoff;
    assign expire     = !holdoff && (timer_q == T_LAST);

    always_comb begin
        prev_raw_d    = raw_word;
        aligned_d     = cat[offset_q +: 10];
        aligned_off_d = offset_q;
        state_d       = state_q;
        offset_d      = offset_q;
        timer_d       = holdoff ? timer_q : timer_q + TW'(1);
        tok_cnt_d     = tok_cnt_q;

        case (state_q)
            ST_SEARCH: begin
                if (tok_seen) begin
                    state_d   = (LOCK_TOKENS <= 1) ? ST_LOCKED : ST_VERIFY;
                    tok_cnt_d = CW'(1);
                    timer_d   = '0;
                end else if (expire) begin
                    offset_d = offset_adv;
                    timer_d  = '0;
                end
            end
            ST_VERIFY: begin
                if (tok_seen) begin
                    tok_cnt_d = tok_cnt_q + CW'(1);
                    timer_d   = '0;
                    if (tok_cnt_q + CW'(1) >= L_TOK) begin
                        state_d = ST_LOCKED;
                    end
                end else if (expire) begin
                    state_d   = ST_SEARCH;
                    offset_d  = offset_adv;
                    tok_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (tok_seen) begin
                    timer_d = '0;
                end else if (expire) begin
                    state_d   = ST_SEARCH;
                    tok_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                tok_cnt_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = 8'd0;
        c_d     = 2'b00;
        de_d    = 1'b0;
        valid_d = 1'b0;
        if (state_d == ST_LOCKED) begin
            valid_d = 1'b1;
            if (sym_is_token) begin
                c_d = sym_c;
            end else begin
                de_d   = 1'b1;
                data_d = sym_data;
                c_d    = c_q;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            prev_raw_q    <= '0;
            aligned_q     <= '0;
            aligned_off_q <= '0;
            state_q       <= ST_SEARCH;
            offset_q      <= '0;
            timer_q       <= '0;
            tok_cnt_q     <= '0;
            data_q        <= '0;
            c_q           <= '0;
            de_q          <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            prev_raw_q    <= prev_raw_d;
            aligned_q     <= aligned_d;
            aligned_off_q <= aligned_off_d;
            state_q       <= state_d;
            offset_q      <= offset_d;
            timer_q       <= timer_d;
            tok_cnt_q     <= tok_cnt_d;
            data_q        <= data_d;
            c_q           <= c_d;
            de_q          <= de_d;
            valid_q       <= valid_d;
        end
    end

    assign data   = data_q;
    assign c      = c_q;
    assign de     = de_q;
    assign valid  = valid_q;
    assign locked = (state_q == ST_LOCKED);
    assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

    localparam int SW = 256;
    localparam int LT = 32;
    localparam logic [9:0] TK00 = 10'b1101010100;
    localparam logic [9:0] TK01 = 10'b0010101011;
    localparam logic [9:0] TK10 = 10'b0101010100;
    localparam logic [9:0] TK11 = 10'b1010101011;

    logic       pixclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic [7:0] data;
    logic [1:0] c;
    logic       de, valid, locked;
    logic [3:0] offset;

    int vectors = 0;
    int miscompares = 0;
    int enc_cnt = 0;
    bit sq[$];

    logic [9:0] m_prev, m_al;
    int         m_al_off, m_off, m_timer, m_tok, m_mode;
    logic [7:0] m_data;
    logic [1:0] m_c;
    logic       m_de, m_valid;

    tmds_channel_decoder #(.SEARCH_WINDOW(SW), .LOCK_TOKENS(LT)) dut (
        .pixclk   (pixclk),
        .rst      (rst),
        .raw_word (raw_word),
        .data     (data),
        .c        (c),
        .de       (de),
        .valid    (valid),
        .locked   (locked),
        .offset   (offset)
    );

    always #5 pixclk = ~pixclk;

    function automatic logic [9:0] token_of(input int i);
        case (i % 4)
            0: return TK00;
            1: return TK01;
            2: return TK10;
            default: return TK11;
        endcase
    endfunction

    function automatic int tok_code(input logic [9:0] q);
        if (q == TK00) return 0;
        if (q == TK01) return 1;
        if (q == TK10) return 2;
        if (q == TK11) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] d, r;
        d = q[9] ? ~q[7:0] : q[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) r[i] = d[i] ^ d[i-1] ^ ~q[8];
        return r;
    endfunction

    // DVI transmit encoder with running disparity
    function automatic logic [9:0] tmds_enc(input logic [7:0] din);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1 = $countones(din);
        qm[0] = din[0];
        if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return q;
    endfunction

    // reference behaviour for one pixclk edge
    task automatic model_edge(input logic [9:0] w, input bit r);
        logic [9:0] new_al;
        int old_off, tc, pos;
        bit skip, tok, exp;
        if (r) begin
            m_prev = 0; m_al = 0; m_al_off = 0; m_off = 0; m_timer = 0; m_tok = 0;
            m_mode = 0; m_data = 0; m_c = 0; m_de = 0; m_valid = 0;
            return;
        end
        for (int b = 0; b < 10; b++) begin
            pos = m_off + b;
            new_al[b] = (pos < 10) ? m_prev[pos] : w[pos-10];
        end
        old_off = m_off;
        skip = (m_al_off != m_off);
        tc = tok_code(m_al);
        tok = !skip && tc >= 0;
        exp = !skip && m_timer == SW - 1;
        if (tok) begin
            m_timer = 0;
            if (m_mode == 0) begin
                m_mode = (LT <= 1) ? 2 : 1;
                m_tok = 1;
            end else if (m_mode == 1) begin
                m_tok++;
                if (m_tok >= LT) m_mode = 2;
            end
        end else if (exp) begin
            m_timer = 0;
            if (m_mode != 2) m_off = (m_off + 1) % 10;
            m_mode = 0;
            m_tok = 0;
        end else if (!skip) begin
            m_timer++;
        end
        if (m_mode == 2) begin
            m_valid = 1;
            if (tc >= 0) begin
                m_de = 0; m_data = 0; m_c = 2'(tc);
            end else begin
                m_de = 1; m_data = ref_decode(m_al);
            end
        end else begin
            m_valid = 0; m_de = 0; m_data = 0; m_c = 0;
        end
        m_prev = w;
        m_al = new_al;
        m_al_off = old_off;
    endtask

    task automatic drive(input logic [9:0] w, input bit r);
        raw_word = w;
        rst = r;
        @(posedge pixclk);
        model_edge(w, r);
        #1;
        vectors++;
        if ({data, c, de, valid, locked, offset} !==
            {m_data, m_c, m_de, m_valid, (m_mode == 2), 4'(m_off)}) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t got data=%h c=%b de=%b valid=%b locked=%b offset=%0d expected data=%h c=%b de=%b valid=%b locked=%b offset=%0d",
                     $time, data, c, de, valid, locked, offset,
                     m_data, m_c, m_de, m_valid, (m_mode == 2), m_off);
        end
    endtask

    task automatic send_sym(input logic [9:0] q);
        logic [9:0] w;
        for (int b = 0; b < 10; b++) sq.push_back(q[b]);
        for (int b = 0; b < 10; b++) w[b] = sq.pop_front();
        drive(w, 1'b0);
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) sq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        sq.delete();
        enc_cnt = 0;
        drive(10'd0, 1'b1);
    endtask

    task automatic send_data();
        send_sym(tmds_enc(8'($urandom_range(0, 255))));
    endtask

    task automatic stream_until_lock(input int spacing, input int max_sends, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_sends; i++) begin
            if (i % spacing == 0) send_sym(token_of(i / spacing));
            else send_data();
            if (locked === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(10'($urandom_range(0, 1023)), 1'b1);
        vectors++;
        if ({data, c, de, valid, locked, offset} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h expected 0", {data, c, de, valid, locked, offset});
        end
    endtask

    task automatic test_aligned_lock();
        do_reset();
        for (int t = 0; t < LT; t++) begin
            send_sym(token_of(t));
            if (t < LT - 1) for (int k = 0; k < 99; k++) send_data();
        end
        send_data();
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_early got locked=%b expected 0", locked);
        end
        send_data();
        vectors++;
        if (locked !== 1'b1 || valid !== 1'b1 || offset !== 4'd0) begin
            miscompares++;
            $display("FAIL lock_after_last_token got locked=%b valid=%b offset=%0d expected 1 1 0", locked, valid, offset);
        end
        send_sym(tmds_enc(8'hA5));
        send_data();
        send_data();
        vectors++;
        if (data !== 8'hA5 || de !== 1'b1) begin
            miscompares++;
            $display("FAIL pixel_a5 got data=%h de=%b expected a5 1", data, de);
        end
    endtask

    task automatic test_control();
        logic [7:0] bytes [10];
        for (int i = 0; i < 10; i++) send_sym(TK10);
        vectors++;
        if (c !== 2'b10 || de !== 1'b0 || data !== 8'd0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL blanking got c=%b de=%b data=%h valid=%b expected 10 0 00 1", c, de, data, valid);
        end
        for (int i = 0; i < 10; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            send_sym(tmds_enc(bytes[i]));
        end
        vectors++;
        if (c !== 2'b10 || de !== 1'b1 || data !== bytes[7]) begin
            miscompares++;
            $display("FAIL active_after_blank got c=%b de=%b data=%h expected 10 1 %h", c, de, data, bytes[7]);
        end
    endtask

    task automatic test_loss_of_lock();
        bit ok;
        send_sym(TK00);
        for (int i = 0; i < 257; i++) send_data();
        vectors++;
        if (locked !== 1'b1 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_early got locked=%b valid=%b expected 1 1", locked, valid);
        end
        send_data();
        vectors++;
        if (locked !== 1'b0 || valid !== 1'b0 || offset !== 4'd0) begin
            miscompares++;
            $display("FAIL loss_drop got locked=%b valid=%b offset=%0d expected 0 0 0", locked, valid, offset);
        end
        stream_until_lock(100, 6000, ok);
        vectors++;
        if (!ok || offset !== 4'd0) begin
            miscompares++;
            $display("FAIL relock got locked=%b offset=%0d expected 1 0", ok, offset);
        end
    endtask

    task automatic test_rotated();
        logic [7:0] bytes [40];
        logic [3:0] prev_off;
        bit ok;
        do_reset();
        push_junk(7);
        ok = 1'b0;
        prev_off = offset;
        for (int i = 0; i < 12000; i++) begin
            if (i % 100 == 0) send_sym(token_of(i / 100));
            else send_data();
            if (offset !== prev_off) begin
                vectors++;
                if (offset !== 4'((prev_off + 1) % 10)) begin
                    miscompares++;
                    $display("FAIL offset_step got %0d expected %0d", offset, (prev_off + 1) % 10);
                end
                prev_off = offset;
            end
            if (locked === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || offset !== 4'd7) begin
            miscompares++;
            $display("FAIL rotated_lock got locked=%b offset=%0d expected 1 7", ok, offset);
        end
        for (int i = 0; i < 40; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            send_sym(tmds_enc(bytes[i]));
            if (i >= 2) begin
                vectors++;
                if (data !== bytes[i-2] || de !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rotated_byte got data=%h de=%b expected %h 1", data, de, bytes[i-2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        push_junk(4);
        stream_until_lock(100, 12000, ok);
        vectors++;
        if (!ok || offset !== 4'd4) begin
            miscompares++;
            $display("FAIL lock_at_4 got locked=%b offset=%0d expected 1 4", ok, offset);
        end
        drive(10'($urandom_range(0, 1023)), 1'b1);
        vectors++;
        if ({data, c, de, valid, locked, offset} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid got %h expected 0", {data, c, de, valid, locked, offset});
        end
        sq.delete();
        for (int i = 0; i < 20; i++) drive(10'd0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [3:0] prev_off;
        bit seen;
        do_reset();
        seen = 1'b0;
        prev_off = offset;
        for (int i = 0; i < 3000 && !seen; i++) begin
            drive(10'd0, 1'b0);
            if (prev_off == 4'd9 && offset !== 4'd9) begin
                seen = 1'b1;
                vectors++;
                if (offset !== 4'd0) begin
                    miscompares++;
                    $display("FAIL wrap_value got %0d expected 0", offset);
                end
            end
            prev_off = offset;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wrap_seen got 0 expected 1");
        end
    endtask

    task automatic test_expiry_token();
        do_reset();
        for (int i = 0; i < 253; i++) drive(10'd0, 1'b0);
        drive(TK00, 1'b0);
        drive(10'd0, 1'b0);
        drive(10'd0, 1'b0);
        vectors++;
        if (offset !== 4'd0) begin
            miscompares++;
            $display("FAIL expiry_token got offset=%0d expected 0", offset);
        end
        for (int i = 0; i < 300; i++) drive(10'd0, 1'b0);
        vectors++;
        if (offset !== 4'd1) begin
            miscompares++;
            $display("FAIL verify_expiry got offset=%0d expected 1", offset);
        end
    endtask

    task automatic test_holdoff();
        do_reset();
        for (int i = 0; i < 254; i++) drive(10'd0, 1'b0);
        drive(TK00, 1'b0);
        drive(10'd0, 1'b0);
        vectors++;
        if (offset !== 4'd1) begin
            miscompares++;
            $display("FAIL holdoff_advance got offset=%0d expected 1", offset);
        end
        push_junk(1);
        for (int t = 0; t < LT; t++) begin
            send_sym(token_of(t));
            for (int k = 0; k < 3; k++) send_data();
            if (t == LT - 2) begin
                vectors++;
                if (locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL holdoff_counted got locked=%b expected 0", locked);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || offset !== 4'd1) begin
            miscompares++;
            $display("FAIL holdoff_lock got locked=%b offset=%0d expected 1 1", locked, offset);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_control();
        test_loss_of_lock();
        test_rotated();
        test_reset_mid();
        test_wrap();
        test_expiry_token();
        test_holdoff();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
